// File: rtl/axi4_echo_ram_slave.sv
// AXI4 slave backed by a 64-bit wide RAM; returns the request's echo tag alongside ID on B and R.
// Latency: B one cycle after the last W beat; first R beat one cycle after the AR handshake.
// Backpressure: b_valid/r_valid hold a stable payload until b_ready/r_ready; one burst per direction at a time.
module axi4_echo_ram_slave #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic        aw_id,
  input  logic [6:0]  aw_echo_extra_id,
  input  logic [31:0] aw_addr,
  input  logic [7:0]  aw_len,
  input  logic [2:0]  aw_size,
  input  logic [1:0]  aw_burst,
  input  logic [3:0]  aw_cache,
  input  logic [2:0]  aw_prot,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [63:0] w_data,
  input  logic [7:0]  w_strb,
  input  logic        w_last,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        b_id,
  output logic [6:0]  b_echo_extra_id,
  output logic [1:0]  b_resp,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic        ar_id,
  input  logic [6:0]  ar_echo_extra_id,
  input  logic [31:0] ar_addr,
  input  logic [7:0]  ar_len,
  input  logic [2:0]  ar_size,
  input  logic [1:0]  ar_burst,
  input  logic [3:0]  ar_cache,
  input  logic [2:0]  ar_prot,
  output logic        r_valid,
  input  logic        r_ready,
  output logic        r_id,
  output logic [6:0]  r_echo_extra_id,
  output logic [63:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_last
);

  localparam int          IW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 8);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // Reserved burst type wins over an out-of-range address.
  function automatic logic [1:0] err_code(input logic [31:0] addr, input logic [1:0] burst);
    if (burst == 2'b11)        return RESP_SLVERR;
    else if (addr >= MEM_BYTES) return RESP_DECERR;
    else                        return RESP_OKAY;
  endfunction

  // FIXED holds the address; INCR and WRAP both step by the beat size.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    if (burst == 2'b00) return addr;
    else                return addr + (32'd1 << size);
  endfunction

  logic [63:0] mem [MEM_WORDS];

  w_state_t    w_state;
  logic        wr_id;
  logic [6:0]  wr_echo;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic [2:0]  wr_size;
  logic [1:0]  wr_burst;
  logic [1:0]  wr_code;
  logic [8:0]  wr_cnt;
  logic        w_fire;

  r_state_t    r_state;
  logic        rd_id;
  logic [6:0]  rd_echo;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic [2:0]  rd_size;
  logic [1:0]  rd_burst;
  logic [7:0]  rd_cnt;

  // Cache and protection attributes have no effect on a plain RAM.
  logic unused_attr;
  assign unused_attr = ^{aw_cache, aw_prot, ar_cache, ar_prot};

  assign w_fire          = w_valid && w_ready;
  assign b_id            = wr_id;
  assign b_echo_extra_id = wr_echo;
  assign r_id            = rd_id;
  assign r_echo_extra_id = rd_echo;
  // Combinational read: a same-cycle write is seen only from the next cycle.
  assign r_data = (r_valid && r_resp == RESP_OKAY) ? mem[rd_addr[IW+2:3]] : '0;

  // Write FSM: accept AW, absorb W beats until w_last, then hold B until accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b1;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      wr_id    <= 1'b0;
      wr_echo  <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_code  <= RESP_OKAY;
      wr_cnt   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_valid) begin
          wr_id    <= aw_id;
          wr_echo  <= aw_echo_extra_id;
          wr_addr  <= aw_addr;
          wr_len   <= aw_len;
          wr_size  <= aw_size;
          wr_burst <= aw_burst;
          wr_code  <= err_code(aw_addr, aw_burst);
          wr_cnt   <= '0;
          aw_ready <= 1'b0;
          w_ready  <= 1'b1;
          w_state  <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
          wr_cnt  <= wr_cnt + 9'd1;
          if (w_last) begin
            w_ready <= 1'b0;
            b_valid <= 1'b1;
            w_state <= W_RESP;
            // Address-phase errors take precedence over a beat-count mismatch.
            if (wr_code != RESP_OKAY)
              b_resp <= wr_code;
            else if ((wr_cnt + 9'd1) != ({1'b0, wr_len} + 9'd1))
              b_resp <= RESP_SLVERR;
            else
              b_resp <= RESP_OKAY;
          end
        end
        W_RESP: if (b_ready) begin
          b_valid  <= 1'b0;
          aw_ready <= 1'b1;
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM write port: only bursts with a clean address phase touch memory; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_fire && wr_code == RESP_OKAY) begin
      for (int b = 0; b < 8; b++) begin
        if (w_strb[b]) mem[wr_addr[IW+2:3]][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Read FSM: accept AR, then stream len+1 beats, each held until r_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b1;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_resp   <= RESP_OKAY;
      rd_id    <= 1'b0;
      rd_echo  <= '0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_valid) begin
          rd_id    <= ar_id;
          rd_echo  <= ar_echo_extra_id;
          rd_addr  <= ar_addr;
          rd_len   <= ar_len;
          rd_size  <= ar_size;
          rd_burst <= ar_burst;
          rd_cnt   <= '0;
          r_resp   <= err_code(ar_addr, ar_burst);
          r_valid  <= 1'b1;
          r_last   <= (ar_len == 8'd0);
          ar_ready <= 1'b0;
          r_state  <= R_DATA;
        end
        R_DATA: if (r_ready) begin
          if (r_last) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            ar_ready <= 1'b1;
            r_state  <= R_IDLE;
          end else begin
            rd_addr <= next_addr(rd_addr, rd_size, rd_burst);
            rd_cnt  <= rd_cnt + 8'd1;
            r_last  <= ((rd_cnt + 8'd1) == rd_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_echo_ram_slave.sv
// Testbench for axi4_echo_ram_slave: directed scenarios plus randomized bursts
// checked against a word-array model of the RAM and the response rules.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that point.
module tb_axi4_echo_ram_slave;
  localparam int MEM_WORDS = 256;

  logic        clock, reset_n;
  logic        aw_valid, aw_ready, aw_id;
  logic [6:0]  aw_echo_extra_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_cache;
  logic [2:0]  aw_prot;
  logic        w_valid, w_ready, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready, b_id;
  logic [6:0]  b_echo_extra_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready, ar_id;
  logic [6:0]  ar_echo_extra_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_cache;
  logic [2:0]  ar_prot;
  logic        r_valid, r_ready, r_id, r_last;
  logic [6:0]  r_echo_extra_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] ref_mem [MEM_WORDS];
  logic [63:0] wq [512];
  logic [7:0]  sq [512];
  logic [63:0] rdq [512];
  logic [1:0]  rrq [512];
  logic        rlq [512];
  logic        riq [512];
  logic [6:0]  req [512];

  axi4_echo_ram_slave #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock(clock), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_echo_extra_id(aw_echo_extra_id),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_cache(aw_cache), .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_echo_extra_id(b_echo_extra_id),
    .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_echo_extra_id(ar_echo_extra_id),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_cache(ar_cache), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_echo_extra_id(r_echo_extra_id),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_code(input logic [31:0] addr, input logic [1:0] burst);
    if (burst == 2'b11) return 2'b10;
    if (addr >= 32'(MEM_WORDS * 8)) return 2'b11;
    return 2'b00;
  endfunction

  // Word touched by beat n of a burst, computed directly from the start address.
  function automatic int model_idx(input logic [31:0] base, input logic [2:0] size,
                                   input logic [1:0] burst, input int beat);
    logic [31:0] a;
    a = (burst == 2'b00) ? base : base + 32'(beat) * (32'd1 << size);
    return int'((a >> 3) % 32'(MEM_WORDS));
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int nbeats, output logic [1:0] exp_resp);
    logic [1:0] code;
    int idx;
    code = model_code(addr, burst);
    for (int i = 0; i < nbeats; i++) begin
      if (code == 2'b00) begin
        idx = model_idx(addr, size, burst, i);
        for (int b = 0; b < 8; b++) if (sq[i][b]) ref_mem[idx][8*b +: 8] = wq[i][8*b +: 8];
      end
    end
    if (code != 2'b00)               exp_resp = code;
    else if (nbeats != int'(len) + 1) exp_resp = 2'b10;
    else                              exp_resp = 2'b00;
  endtask

  // ---------------- bus drivers ----------------
  task automatic timeout(input string what);
    vectors++;
    miscompares++;
    $display("FAIL timeout_%s: handshake not seen within budget, required within 200 cycles", what);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input logic [6:0] echo,
                          input int nbeats, input bit stalls,
                          output logic [1:0] resp, output logic bid, output logic [6:0] becho);
    int t;
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    aw_id = id; aw_echo_extra_id = echo; aw_cache = 4'($urandom); aw_prot = 3'($urandom);
    t = 0;
    while (!aw_ready && t < 200) begin @(posedge clock); #1; t++; end
    if (t >= 200) timeout("aw");
    @(posedge clock); #1;
    aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (stalls) while ($urandom_range(3) == 0) begin @(posedge clock); #1; end
      w_valid = 1'b1; w_data = wq[i]; w_strb = sq[i]; w_last = (i == nbeats - 1);
      t = 0;
      while (!w_ready && t < 200) begin @(posedge clock); #1; t++; end
      if (t >= 200) timeout("w");
      @(posedge clock); #1;
      w_valid = 1'b0; w_last = 1'b0;
    end
    if (stalls) while ($urandom_range(2) == 0) begin @(posedge clock); #1; end
    b_ready = 1'b1;
    t = 0;
    while (!b_valid && t < 200) begin @(posedge clock); #1; t++; end
    if (t >= 200) timeout("b");
    resp = b_resp; bid = b_id; becho = b_echo_extra_id;
    @(posedge clock); #1;
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic id, input logic [6:0] echo,
                         input bit stalls, output int nb, output logic first_vld);
    int t;
    bit done;
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    ar_id = id; ar_echo_extra_id = echo; ar_cache = 4'($urandom); ar_prot = 3'($urandom);
    t = 0;
    while (!ar_ready && t < 200) begin @(posedge clock); #1; t++; end
    if (t >= 200) timeout("ar");
    @(posedge clock); #1;
    ar_valid = 1'b0;
    first_vld = r_valid;
    nb = 0; t = 0; done = 1'b0;
    while (!done && t < 2000) begin
      r_ready = stalls ? ($urandom_range(3) != 0) : 1'b1;
      if (r_valid && r_ready) begin
        rdq[nb] = r_data; rrq[nb] = r_resp; rlq[nb] = r_last; riq[nb] = r_id; req[nb] = r_echo_extra_id;
        nb++;
        if (r_last || nb >= 300) done = 1'b1;
      end
      @(posedge clock); #1;
      t++;
    end
    r_ready = 1'b0;
    if (!done) timeout("r");
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_handshakes: got %b required 110000", {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last});
    end
    vectors++;
    if ({b_resp, r_resp, b_id, r_id, b_echo_extra_id, r_echo_extra_id, r_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: got bresp=%h rresp=%h bid=%b rid=%b becho=%h recho=%h rdata=%h required all 0",
               b_resp, r_resp, b_id, r_id, b_echo_extra_id, r_echo_extra_id, r_data);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_fill;
    logic [1:0] resp, exp; logic bid; logic [6:0] becho;
    for (int i = 0; i < MEM_WORDS; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'hFF; end
    do_write(32'h0, 8'(MEM_WORDS - 1), 3'd3, 2'b01, 1'b0, 7'h11, MEM_WORDS, 1'b0, resp, bid, becho);
    model_write(32'h0, 8'(MEM_WORDS - 1), 3'd3, 2'b01, MEM_WORDS, exp);
    vectors++;
    if (resp !== exp) begin miscompares++; $display("FAIL fill_bresp: got %h required %h", resp, exp); end
  endtask

  task automatic test_single;
    logic [1:0] resp, exp; logic bid; logic [6:0] becho; int nb; logic fv;
    wq[0] = 64'h1122334455667788; sq[0] = 8'hFF;
    do_write(32'h10, 8'd0, 3'd3, 2'b01, 1'b1, 7'h5A, 1, 1'b0, resp, bid, becho);
    model_write(32'h10, 8'd0, 3'd3, 2'b01, 1, exp);
    vectors++;
    if (aw_ready !== 1'b1) begin miscompares++; $display("FAIL single_aw_ready_after_b: got %b required 1", aw_ready); end
    vectors++;
    if ({resp, bid, becho} !== {exp, 1'b1, 7'h5A}) begin
      miscompares++; $display("FAIL single_b: got resp=%h id=%b echo=%h required resp=%h id=1 echo=5a", resp, bid, becho, exp);
    end
    do_read(32'h10, 8'd0, 3'd3, 2'b01, 1'b1, 7'h5A, 1'b0, nb, fv);
    vectors++;
    if (fv !== 1'b1) begin miscompares++; $display("FAIL single_r_latency: r_valid=%b one cycle after AR, required 1", fv); end
    vectors++;
    if (nb != 1 || rdq[0] !== ref_mem[2] || rdq[0] !== 64'h1122334455667788) begin
      miscompares++; $display("FAIL single_rdata: beats=%0d data=%h required beats=1 data=1122334455667788", nb, rdq[0]);
    end
    vectors++;
    if ({rlq[0], rrq[0], riq[0], req[0]} !== {1'b1, 2'b00, 1'b1, 7'h5A}) begin
      miscompares++; $display("FAIL single_rattr: last=%b resp=%h id=%b echo=%h required 1/0/1/5a", rlq[0], rrq[0], riq[0], req[0]);
    end
  endtask

  task automatic test_incr;
    logic [1:0] resp, exp; logic bid; logic [6:0] becho; int nb; logic fv;
    for (int i = 0; i < 4; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'hFF; end
    do_write(32'h0, 8'd3, 3'd3, 2'b01, 1'b0, 7'h23, 4, 1'b1, resp, bid, becho);
    model_write(32'h0, 8'd3, 3'd3, 2'b01, 4, exp);
    vectors++;
    if (resp !== exp) begin miscompares++; $display("FAIL incr_bresp: got %h required %h", resp, exp); end
    do_read(32'h0, 8'd3, 3'd3, 2'b01, 1'b0, 7'h23, 1'b1, nb, fv);
    vectors++;
    if (nb != 4) begin miscompares++; $display("FAIL incr_beats: got %0d required 4", nb); end
    for (int i = 0; i < 4 && i < nb; i++) begin
      vectors++;
      if (rdq[i] !== wq[i] || rlq[i] !== (i == 3)) begin
        miscompares++; $display("FAIL incr_beat%0d: data=%h last=%b required data=%h last=%b", i, rdq[i], rlq[i], wq[i], i == 3);
      end
    end
  endtask

  task automatic test_strobe;
    logic [1:0] resp, exp; logic bid; logic [6:0] becho; int nb; logic fv;
    wq[0] = '1; sq[0] = 8'hFF;
    do_write(32'h40, 8'd0, 3'd3, 2'b01, 1'b0, 7'h01, 1, 1'b0, resp, bid, becho);
    model_write(32'h40, 8'd0, 3'd3, 2'b01, 1, exp);
    wq[0] = '0; sq[0] = 8'h0F;
    do_write(32'h40, 8'd0, 3'd3, 2'b01, 1'b0, 7'h02, 1, 1'b0, resp, bid, becho);
    model_write(32'h40, 8'd0, 3'd3, 2'b01, 1, exp);
    do_read(32'h40, 8'd0, 3'd3, 2'b01, 1'b0, 7'h03, 1'b0, nb, fv);
    vectors++;
    if (rdq[0] !== 64'hFFFFFFFF00000000 || rdq[0] !== ref_mem[8]) begin
      miscompares++; $display("FAIL strobe_rdata: got %h required ffffffff00000000", rdq[0]);
    end
  endtask

  task automatic test_errors;
    logic [1:0] resp, exp; logic bid; logic [6:0] becho; int nb; logic fv;
    wq[0] = {$urandom, $urandom}; sq[0] = 8'hFF;
    do_write(32'(MEM_WORDS * 8), 8'd0, 3'd3, 2'b01, 1'b1, 7'h44, 1, 1'b0, resp, bid, becho);
    model_write(32'(MEM_WORDS * 8), 8'd0, 3'd3, 2'b01, 1, exp);
    vectors++;
    if (resp !== 2'b11) begin miscompares++; $display("FAIL decerr_bresp: got %h required 3", resp); end
    do_read(32'h0, 8'd0, 3'd3, 2'b01, 1'b0, 7'h45, 1'b0, nb, fv);
    vectors++;
    if (rdq[0] !== ref_mem[0]) begin miscompares++; $display("FAIL decerr_ram_unchanged: got %h required %h", rdq[0], ref_mem[0]); end
    do_read(32'h8, 8'd1, 3'd3, 2'b11, 1'b1, 7'h46, 1'b0, nb, fv);
    vectors++;
    if (nb != 2 || rdq[0] !== 64'h0 || rrq[0] !== 2'b10 || rlq[1] !== 1'b1) begin
      miscompares++; $display("FAIL slverr_read: beats=%0d data=%h resp=%h last1=%b required 2/0/2/1", nb, rdq[0], rrq[0], rlq[1]);
    end
  endtask

  task automatic test_short_burst;
    logic [1:0] resp, exp; logic bid; logic [6:0] becho;
    for (int i = 0; i < 2; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'hFF; end
    do_write(32'h200, 8'd3, 3'd3, 2'b01, 1'b0, 7'h30, 2, 1'b0, resp, bid, becho);
    model_write(32'h200, 8'd3, 3'd3, 2'b01, 2, exp);
    vectors++;
    if (resp !== 2'b10 || exp !== 2'b10) begin miscompares++; $display("FAIL short_bresp: got %h required 2", resp); end
  endtask

  task automatic test_random;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst, resp, exp, code;
    logic id, bid, fv; logic [6:0] echo, becho; int nb, nbeats;
    for (int it = 0; it < 40; it++) begin
      addr  = ($urandom_range(7) == 0) ? 32'(MEM_WORDS * 8) + 32'($urandom_range(0, 255) * 8)
                                       : 32'($urandom_range(0, MEM_WORDS * 8 - 1));
      burst = ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      len   = 8'($urandom_range(0, 7));
      size  = 3'($urandom_range(0, 3));
      id    = 1'($urandom_range(0, 1));
      echo  = 7'($urandom);
      if ($urandom_range(1) == 0) begin
        nbeats = ($urandom_range(5) == 0) ? int'($urandom_range(1, int'(len) + 2)) : int'(len) + 1;
        for (int i = 0; i < nbeats; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'($urandom); end
        do_write(addr, len, size, burst, id, echo, nbeats, 1'b1, resp, bid, becho);
        model_write(addr, len, size, burst, nbeats, exp);
        vectors++;
        if ({resp, bid, becho} !== {exp, id, echo}) begin
          miscompares++; $display("FAIL rand_write%0d: resp=%h id=%b echo=%h required %h/%b/%h", it, resp, bid, becho, exp, id, echo);
        end
      end else begin
        code = model_code(addr, burst);
        do_read(addr, len, size, burst, id, echo, 1'b1, nb, fv);
        vectors++;
        if (nb != int'(len) + 1 || fv !== 1'b1) begin
          miscompares++; $display("FAIL rand_read%0d_beats: got %0d first_vld=%b required %0d/1", it, nb, fv, int'(len) + 1);
        end
        for (int i = 0; i <= int'(len) && i < nb; i++) begin
          logic [63:0] ed;
          ed = (code == 2'b00) ? ref_mem[model_idx(addr, size, burst, i)] : 64'h0;
          vectors++;
          if ({rdq[i], rrq[i], rlq[i], riq[i], req[i]} !== {ed, code, i == int'(len), id, echo}) begin
            miscompares++;
            $display("FAIL rand_read%0d_beat%0d: data=%h resp=%h last=%b id=%b echo=%h required %h/%h/%b/%b/%h",
                     it, i, rdq[i], rrq[i], rlq[i], riq[i], req[i], ed, code, i == int'(len), id, echo);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure_reset;
    int t, nb; logic fv; logic [6:0] echo;
    echo = 7'($urandom);
    ar_valid = 1'b1; ar_addr = 32'h80; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'b01;
    ar_id = 1'b1; ar_echo_extra_id = echo;
    t = 0;
    while (!ar_ready && t < 200) begin @(posedge clock); #1; t++; end
    if (t >= 200) timeout("bp_ar");
    @(posedge clock); #1;
    ar_valid = 1'b0; r_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({r_valid, r_last, r_resp, r_id, r_echo_extra_id, r_data} !== {1'b1, 1'b0, 2'b00, 1'b1, echo, ref_mem[16]}) begin
        miscompares++; $display("FAIL bp_hold%0d: valid=%b last=%b resp=%h id=%b echo=%h data=%h required 1/0/0/1/%h/%h",
                                k, r_valid, r_last, r_resp, r_id, r_echo_extra_id, r_data, echo, ref_mem[16]);
      end
      @(posedge clock); #1;
    end
    r_ready = 1'b1;
    @(posedge clock); #1;
    r_ready = 1'b0;
    vectors++;
    if (r_data !== ref_mem[17] || r_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_beat2: valid=%b data=%h required 1/%h", r_valid, r_data, ref_mem[17]);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({r_valid, r_last, ar_ready, r_data} !== {1'b0, 1'b0, 1'b1, 64'h0}) begin
      miscompares++; $display("FAIL rst_mid_read: valid=%b last=%b ar_ready=%b data=%h required 0/0/1/0", r_valid, r_last, ar_ready, r_data);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if ({r_valid, ar_ready} !== 2'b01) begin
      miscompares++; $display("FAIL rst_release_read: valid=%b ar_ready=%b required 0/1", r_valid, ar_ready);
    end
    // Abort a write burst after one accepted beat.
    aw_valid = 1'b1; aw_addr = 32'h100; aw_len = 8'd3; aw_size = 3'd3; aw_burst = 2'b01;
    aw_id = 1'b0; aw_echo_extra_id = 7'h77;
    @(posedge clock); #1;
    aw_valid = 1'b0;
    wq[0] = {$urandom, $urandom}; sq[0] = 8'hFF;
    w_valid = 1'b1; w_data = wq[0]; w_strb = sq[0]; w_last = 1'b0;
    @(posedge clock); #1;
    w_valid = 1'b0;
    ref_mem[32] = wq[0];
    b_ready = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    b_ready = 1'b0;
    vectors++;
    if ({b_valid, w_ready, aw_ready} !== 3'b001) begin
      miscompares++; $display("FAIL rst_mid_write: b_valid=%b w_ready=%b aw_ready=%b required 0/0/1", b_valid, w_ready, aw_ready);
    end
    do_read(32'h100, 8'd0, 3'd3, 2'b01, 1'b0, 7'h00, 1'b0, nb, fv);
    vectors++;
    if (rdq[0] !== ref_mem[32]) begin
      miscompares++; $display("FAIL rst_ram_kept: got %h required %h", rdq[0], ref_mem[32]);
    end
  endtask

  initial begin
    aw_valid = 0; aw_id = 0; aw_echo_extra_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    aw_cache = 0; aw_prot = 0; w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_echo_extra_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    ar_cache = 0; ar_prot = 0; r_ready = 0;
    test_reset();
    test_fill();
    test_single();
    test_incr();
    test_strobe();
    test_errors();
    test_short_burst();
    test_random();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_echo_ram_slave.md
AXI4_ECHO_RAM_SLAVE -- requirements
Module: axi4_echo_ram_slave

Interface
REQ-001 Parameter MEM_WORDS, default 256, is the number of 64-bit RAM words; it SHALL be a power of two, 2..4096.
REQ-002 clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 aw_valid/aw_ready  in/out  1/1  AW handshake.
REQ-005 aw_id, aw_echo_extra_id  input  1, 7  AW ID and echo tag.
REQ-006 aw_addr, aw_len, aw_size, aw_burst  input  32, 8, 3, 2  AW address and burst attributes; aw_cache and aw_prot SHALL be accepted at 4 and 3 bits and ignored.
REQ-007 w_valid/w_ready, w_data, w_strb, w_last  in/out, in, in, in  1/1, 64, 8, 1  W channel.
REQ-008 b_valid/b_ready, b_id, b_echo_extra_id, b_resp  out/in, out, out, out  1/1, 1, 7, 2  B channel.
REQ-009 ar_valid/ar_ready, ar_id, ar_echo_extra_id, ar_addr, ar_len, ar_size, ar_burst  in/out, in...  same widths as AW, with ar_cache and ar_prot accepted and ignored.
REQ-010 r_valid/r_ready, r_id, r_echo_extra_id, r_data, r_resp, r_last  out/in, out...  1/1, 1, 7, 64, 2, 1  R channel.

Function
REQ-011 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP; read FSM states SHALL be R_IDLE and R_DATA; the two FSMs SHALL operate independently.
REQ-012 aw_ready SHALL be 1 only in W_IDLE; an AW handshake SHALL latch the ID, echo tag, address, len, size, burst and an error code, then move to W_DATA.
REQ-013 Error code: SLVERR (2'b10) if burst==2'b11; otherwise DECERR (2'b11) if addr >= MEM_WORDS*8; otherwise OKAY (2'b00).
REQ-014 w_ready SHALL be 1 only in W_DATA; on each W handshake with an OKAY code, byte lanes with strb=1 SHALL be written to word addr[log2(MEM_WORDS)+2:3].
REQ-015 Beat address advance: FIXED (2'b00) SHALL hold the address; INCR (2'b01) and WRAP (2'b10) SHALL add 1<<size, with WRAP treated as INCR; the index SHALL wrap modulo MEM_WORDS.
REQ-016 The W handshake with w_last=1 SHALL move the FSM to W_RESP; if the beat count != len+1, b_resp SHALL be SLVERR unless DECERR already applies.
REQ-017 In W_RESP, b_valid SHALL be 1 with the latched ID and echo tag; the B handshake SHALL return the FSM to W_IDLE, so the next aw_ready is 1 in the following cycle.
REQ-018 ar_ready SHALL be 1 only in R_IDLE; an AR handshake in cycle N SHALL latch the same fields and error code (REQ-013 rules) and assert r_valid in cycle N+1.
REQ-019 In R_DATA, r_data SHALL be the RAM word at the current beat index (combinational read), or zero when the code is not OKAY.
REQ-020 r_resp SHALL be the latched code; r_last SHALL be 1 on beat len+1; the echo tag and ID SHALL be held constant for the whole burst.
REQ-021 Each R handshake SHALL advance the address per REQ-015; the handshake with r_last=1 SHALL return the FSM to R_IDLE.
REQ-022 r_valid and b_valid, once asserted, SHALL stay asserted with stable payload until the handshake completes.
REQ-023 A write edge and a combinational read of the same word in the same cycle SHALL return the old data; the new data SHALL be visible from the next cycle.

Reset
REQ-024 While reset_n=0, both FSMs SHALL go to IDLE, beat counters and latched fields SHALL clear, aw_ready=ar_ready=1, and w_ready=b_valid=r_valid=r_last=0, with b_resp/r_resp, IDs, echo tags and r_data all 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no B or R issued; RAM contents SHALL not be reset.

Verification
REQ-026 Single write, then read: AW addr=0x10, len=0, id=1, echo=0x5A; W data=0x1122334455667788, strb=0xFF -> B id=1, echo=0x5A, OKAY; AR same addr -> R data=0x1122334455667788, last=1, echo=0x5A.
REQ-027 INCR burst: AW addr=0, len=3, size=3, four beats -> AR len=3 returns the four words in order, with r_last only on beat 4.
REQ-028 Partial strobe: write 0xFFFF...FF, then strb=0x0F data=0 -> read returns 0xFFFFFFFF00000000.
REQ-029 Error codes: AW addr=MEM_WORDS*8 -> B DECERR and RAM unchanged; AR burst=2'b11 -> R SLVERR with data=0.
REQ-030 Short burst: AW len=3 with w_last on beat 2 -> B SLVERR after beat 2.
REQ-031 Backpressure and reset: hold r_ready=0 for 5 cycles -> r_valid and payload stable; then reset_n=0 mid-burst -> r_valid=0 and ar_ready=1 on release.
